elastic_pipe_chain: RTL and testbench

- Parametrised replacement for the fixed per-stage pipeline registers between IF/ID/EXE/MEM/WB.
- A chain of STAGES registered slots carries a DATA_W payload (PC, instruction, control bundle) with a valid/ready handshake.
- Provides global freeze, per-stage selective flush (branch kill of younger stages), occupancy tracking and a flush-kill counter.
- Sits between producer and consumer stages in the ARM core pipeline. One instance replaces one or more IF_Stage_Reg-style registers.

---
 rtl/elastic_pipe_chain.sv | 110 +++++++++++
 tb/tb_elastic_pipe_chain.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_chain.sv
// Parametrised valid/ready register chain with global freeze, per-slot flush,
// occupancy tracking and a saturating count of flushed (killed) entries.
module elastic_pipe_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned OCC_W = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              freeze,
  input  logic [STAGES-1:0] flush_mask,
  input  logic              flush_in,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  kill_count
);

  localparam int unsigned KW = CNT_W + 5;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  kill_q, kill_d;
  logic [STAGES-1:0] adv;
  logic [STAGES:0]   src_valid;
  logic [DATA_W-1:0] src_data [STAGES+1];
  logic [4:0]        kills;
  logic [KW-1:0]     kill_sum;

  // Source of slot i is index i: index 0 is the producer, index i+1 is slot i.
  assign src_valid = {valid_q, in_valid & ~flush_in};

  always_comb begin
    src_data[0] = in_data;
    for (int unsigned i = 0; i < STAGES; i++) begin
      src_data[i+1] = data_q[i];
    end
  end

  // Ripple from the output end; a local carry avoids a self-referencing vector.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = out_ready | ~valid_q[STAGES-1];
    adv[STAGES-1] = carry;
    for (int unsigned k = 1; k < STAGES; k++) begin
      carry = carry | ~valid_q[STAGES-1-k];
      adv[STAGES-1-k] = carry;
    end
  end

  assign in_ready   = adv[0] & ~freeze;
  assign out_valid  = valid_q[STAGES-1] & ~freeze;
  assign out_data   = data_q[STAGES-1];
  assign occupancy  = occ_q;
  assign kill_count = kill_q;

  always_comb begin
    logic killed;
    valid_d = '0;
    data_d  = data_q;
    kills   = '0;
    killed  = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      // A held slot that is flushed loses its own entry; a loading slot that is
      // flushed loses whatever arrives. Departing entries are judged downstream.
      if (freeze || !adv[i]) begin
        valid_d[i] = valid_q[i] & ~flush_mask[i];
        killed     = valid_q[i] & flush_mask[i];
      end else begin
        valid_d[i] = src_valid[i] & ~flush_mask[i];
        data_d[i]  = src_data[i];
        killed     = src_valid[i] & flush_mask[i];
      end
      kills = kills + 5'(killed);
    end
  end

  always_comb begin
    occ_d = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  assign kill_sum = KW'(kill_q) + KW'(kills);
  assign kill_d   = (kill_sum > KW'({CNT_W{1'b1}})) ? '1 : kill_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
      occ_q   <= '0;
      kill_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Directed bench for elastic_pipe_chain: STAGES=4 main instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_elastic_pipe_chain;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, freeze, flush_in;
  logic [31:0] in_data;
  logic [3:0]  flush_mask;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [2:0]  occupancy;
  logic [15:0] kill_count;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [2:0]  s_occupancy;
  logic [1:0]  s_kill_count;

  int errors = 0;
  int checks = 0;
  int unsigned exp_kill = 0;

  always #5 clk = ~clk;

  elastic_pipe_chain #(.DATA_W(32), .STAGES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .freeze(freeze), .flush_mask(flush_mask),
    .flush_in(flush_in), .occupancy(occupancy), .kill_count(kill_count)
  );

  elastic_pipe_chain #(.DATA_W(32), .STAGES(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(out_ready), .freeze(freeze), .flush_mask(flush_mask),
    .flush_in(flush_in), .occupancy(s_occupancy), .kill_count(s_kill_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'h1 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd3) begin
      errors++; $display("FAIL reset_fill_occ: got %0d want 3", occupancy);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (occupancy !== 3'd0) begin
      errors++; $display("FAIL reset_occ: got %0d want 0", occupancy);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out: got v=%0b d=%h want v=0 d=0", out_valid, out_data);
    end
    checks++;
    if (kill_count !== 16'd0 || s_kill_count !== 2'd0) begin
      errors++; $display("FAIL reset_kill: got %0d/%0d want 0/0", kill_count, s_kill_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    exp_kill = 0;
  endtask

  task automatic test_streaming();
    logic        exp_v;
    logic [31:0] exp_d;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      in_valid = (cyc <= 3);
      in_data  = 32'h100 + 32'(4 * (cyc - 1));
      #1;
      if (cyc <= 3) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL stream_in_ready c%0d: got %0b want 1", cyc, in_ready);
        end
      end
      tick();
      in_valid = 1'b0;
      exp_v = (cyc >= 4 && cyc <= 6);
      exp_d = 32'h100 + 32'(4 * (cyc - 4));
      checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== exp_d)) begin
        errors++;
        $display("FAIL stream_out c%0d: got v=%0b d=%h want v=%0b d=%h", cyc, out_valid, out_data, exp_v, exp_d);
      end
    end
    checks++;
    if (occupancy !== 3'd0) begin
      errors++; $display("FAIL stream_drained_occ: got %0d want 0", occupancy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 32'h10 + 32'(k);
      #1;
      checks++;
      if (in_ready !== (k < 4)) begin
        errors++; $display("FAIL bp_in_ready k%0d: got %0b want %0b", k, in_ready, (k < 4));
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd4) begin
      errors++; $display("FAIL bp_full_occ: got %0d want 4", occupancy);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h10 + 32'(k)) begin
        errors++; $display("FAIL bp_drain k%0d: got v=%0b d=%h want v=1 d=%h", k, out_valid, out_data, 32'h10 + 32'(k));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL bp_empty: got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    logic [31:0] seq [4];
    seq[0] = 32'hD; seq[1] = 32'hC; seq[2] = 32'hB; seq[3] = 32'hA;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = seq[k];
      tick();
    end
    in_valid = 1'b0;
    // Stalled chain: slots 0 (A) and 1 (B) are valid and not departing.
    flush_mask = 4'b0011;
    tick();
    flush_mask = 4'b0000;
    exp_kill += 2;
    checks++;
    if (occupancy !== 3'd2 || kill_count !== 16'(exp_kill)) begin
      errors++; $display("FAIL flush_sel: got occ=%0d kill=%0d want occ=2 kill=%0d", occupancy, kill_count, exp_kill);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== seq[k]) begin
        errors++; $display("FAIL flush_emerge k%0d: got v=%0b d=%h want v=1 d=%h", k, out_valid, out_data, seq[k]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL flush_no_ab: got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
    in_valid = 1'b1; in_data = 32'hE;
    tick();
    in_valid = 1'b0;
    flush_mask = 4'b0010;
    tick();
    flush_mask = 4'b0000;
    exp_kill += 1;
    checks++;
    if (occupancy !== 3'd0 || kill_count !== 16'(exp_kill)) begin
      errors++; $display("FAIL flush_moving: got occ=%0d kill=%0d want occ=0 kill=%0d", occupancy, kill_count, exp_kill);
    end
    in_valid = 1'b1; flush_in = 1'b1; in_data = 32'hF;
    tick();
    in_valid = 1'b0; flush_in = 1'b0;
    checks++;
    if (occupancy !== 3'd0 || kill_count !== 16'(exp_kill)) begin
      errors++; $display("FAIL flush_in: got occ=%0d kill=%0d want occ=0 kill=%0d", occupancy, kill_count, exp_kill);
    end
  endtask

  task automatic test_freeze();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hAA; tick();
    in_data = 32'hBB; tick();
    in_valid = 1'b0; tick(); tick();
    freeze = 1'b1; in_valid = 1'b1; in_data = 32'hCC; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL freeze_hs k%0d: got rdy=%0b v=%0b want 0/0", k, in_ready, out_valid);
      end
      tick();
      checks++;
      if (occupancy !== 3'd2 || out_data !== 32'hAA) begin
        errors++; $display("FAIL freeze_hold k%0d: got occ=%0d d=%h want occ=2 d=aa", k, occupancy, out_data);
      end
    end
    flush_mask = 4'b1111;
    tick();
    flush_mask = 4'b0000;
    exp_kill += 2;
    checks++;
    if (occupancy !== 3'd0 || kill_count !== 16'(exp_kill)) begin
      errors++; $display("FAIL freeze_flush: got occ=%0d kill=%0d want occ=0 kill=%0d", occupancy, kill_count, exp_kill);
    end
    in_valid = 1'b0; freeze = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL unfreeze_empty: got v=%0b rdy=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturation();
    int unsigned exp_sat;
    rst = 1'b0; tick(); rst = 1'b1;
    exp_kill = 0;
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_data = 32'h200 + 32'(k); flush_mask = 4'b0001;
      tick();
      exp_kill += 1;
      exp_sat = (exp_kill > 3) ? 3 : exp_kill;
      checks++;
      if (kill_count !== 16'(exp_kill) || s_kill_count !== 2'(exp_sat)) begin
        errors++;
        $display("FAIL sat_kill k%0d: got %0d/%0d want %0d/%0d", k, kill_count, s_kill_count, exp_kill, exp_sat);
      end
    end
    in_valid = 1'b0; flush_mask = 4'b0000;
    tick();
    checks++;
    if (s_kill_count !== 2'd3 || occupancy !== 3'd0) begin
      errors++; $display("FAIL sat_hold: got kill=%0d occ=%0d want kill=3 occ=0", s_kill_count, occupancy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    freeze = 1'b0; flush_mask = '0; flush_in = 1'b0;
    tick(); tick();
    rst = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_freeze();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
